// File: rtl/bg_tile_fetch_seq.sv
// rtl/bg_tile_fetch_seq.sv - PPU background tile fetch sequencer (NT, AT, PL, PH reads -> tile record)
// Optional stall counter output enabled by BG_FETCH_STALL_CNT_EN.
module bg_tile_fetch_seq #(
    parameter int          CNT_W   = 6,
    parameter logic [15:0] AT_BASE = 16'h03C0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      nt_start_addr,
    input  logic [CNT_W-1:0] tile_count,
    input  logic             pt_sel,
    input  logic [2:0]       fine_y,
    output logic             vram_req,
    output logic [15:0]      vram_addr,
    input  logic             vram_gnt,
    input  logic             vram_rvalid,
    input  logic [7:0]       vram_rdata,
    output logic             tile_valid,
    output logic [7:0]       tile_pt_lo,
    output logic [7:0]       tile_pt_hi,
    output logic [1:0]       tile_pal,
`ifdef BG_FETCH_STALL_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic             busy,
    output logic             done
);

    typedef enum logic [3:0] {
        IDLE, NT_REQ, NT_WAIT, AT_REQ, AT_WAIT,
        PL_REQ, PL_WAIT, PH_REQ, PH_WAIT, EMIT
    } state_t;

    state_t             state, state_nxt;
    logic [15:0]        cur_addr;
    logic [CNT_W-1:0]   remaining;
    logic               pt_sel_q;
    logic [2:0]         fine_y_q;
    logic [7:0]         nt_byte;
    logic [7:0]         at_byte;
    logic [7:0]         pl_byte;
    logic               aborting;
    logic               done_set;
    logic               is_req;
    logic               is_wait;
    logic               read_ok;
    logic               start_ok;
    logic [15:0]        base;
    logic [4:0]         row;
    logic [4:0]         col;
    logic [15:0]        at_addr;
    logic [15:0]        req_addr;
    logic [1:0]         pal_nxt;

    assign base    = {cur_addr[15:10], 10'b0};
    assign row     = cur_addr[9:5];
    assign col     = cur_addr[4:0];
    // One attribute byte covers a 4x4 tile block; 8 blocks per attribute row.
    assign at_addr = base + AT_BASE + {10'b0, row[4:2], 3'b000} + {13'b0, col[4:2]};

    assign is_req  = (state == NT_REQ) || (state == AT_REQ) ||
                     (state == PL_REQ) || (state == PH_REQ);
    assign is_wait = (state == NT_WAIT) || (state == AT_WAIT) ||
                     (state == PL_WAIT) || (state == PH_WAIT);
    assign start_ok = (state == IDLE) && start;
    // Read data is only kept when the run has not been aborted.
    assign read_ok  = is_wait && vram_rvalid && !aborting && !abort;

    always_comb begin
        req_addr = cur_addr;
        case (state)
            AT_REQ:  req_addr = at_addr;
            PL_REQ:  req_addr = {3'b000, pt_sel_q, nt_byte, 1'b0, fine_y_q};
            PH_REQ:  req_addr = {3'b000, pt_sel_q, nt_byte, 1'b1, fine_y_q};
            default: req_addr = cur_addr;
        endcase
    end

    always_comb begin
        pal_nxt = at_byte[1:0];
        case ({row[1], col[1]})
            2'd0:    pal_nxt = at_byte[1:0];
            2'd1:    pal_nxt = at_byte[3:2];
            2'd2:    pal_nxt = at_byte[5:4];
            default: pal_nxt = at_byte[7:6];
        endcase
    end

    assign vram_req   = is_req && !abort;
    assign vram_addr  = is_req ? req_addr : 16'h0000;
    assign tile_valid = (state == EMIT);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (tile_count == '0) done_set = 1'b1;
                    else                  state_nxt = NT_REQ;
                end
            end
            NT_REQ, AT_REQ, PL_REQ, PH_REQ: begin
                if (abort) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end else if (vram_gnt) begin
                    case (state)
                        NT_REQ:  state_nxt = NT_WAIT;
                        AT_REQ:  state_nxt = AT_WAIT;
                        PL_REQ:  state_nxt = PL_WAIT;
                        default: state_nxt = PH_WAIT;
                    endcase
                end
            end
            NT_WAIT, AT_WAIT, PL_WAIT, PH_WAIT: begin
                if (vram_rvalid) begin
                    if (aborting || abort) begin
                        state_nxt = IDLE;
                        done_set  = 1'b1;
                    end else begin
                        case (state)
                            NT_WAIT: state_nxt = AT_REQ;
                            AT_WAIT: state_nxt = PL_REQ;
                            PL_WAIT: state_nxt = PH_REQ;
                            default: state_nxt = EMIT;
                        endcase
                    end
                end
            end
            EMIT: begin
                if ((remaining == CNT_W'(1)) || abort) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end else begin
                    state_nxt = NT_REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr   <= 16'h0000;
            remaining  <= '0;
            pt_sel_q   <= 1'b0;
            fine_y_q   <= 3'd0;
            nt_byte    <= 8'h00;
            at_byte    <= 8'h00;
            pl_byte    <= 8'h00;
            aborting   <= 1'b0;
            done       <= 1'b0;
            tile_pt_lo <= 8'h00;
            tile_pt_hi <= 8'h00;
            tile_pal   <= 2'd0;
        end else begin
            done     <= done_set;
            aborting <= (state_nxt != IDLE) && (aborting || (is_wait && abort));
            if (start_ok) begin
                cur_addr  <= nt_start_addr;
                remaining <= tile_count;
                pt_sel_q  <= pt_sel;
                fine_y_q  <= fine_y;
            end
            if (read_ok) begin
                case (state)
                    NT_WAIT: nt_byte <= vram_rdata;
                    AT_WAIT: at_byte <= vram_rdata;
                    PL_WAIT: pl_byte <= vram_rdata;
                    default: begin
                        tile_pt_lo <= pl_byte;
                        tile_pt_hi <= vram_rdata;
                        tile_pal   <= pal_nxt;
                    end
                endcase
            end
            if (state == EMIT) begin
                remaining <= remaining - CNT_W'(1);
                // Column wrap crosses into the horizontally adjacent nametable.
                if (col == 5'd31) begin
                    cur_addr <= {cur_addr[15:11], ~cur_addr[10], cur_addr[9:5], 5'd0};
                end else begin
                    cur_addr <= {cur_addr[15:5], col + 5'd1};
                end
            end
        end
    end

`ifdef BG_FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'h0000;
        end else if (start_ok) begin
            stall_cnt <= 16'h0000;
        end else if (((is_req && !vram_gnt) || (is_wait && !vram_rvalid)) &&
                     (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bg_tile_fetch_seq.sv
// tb/tb_bg_tile_fetch_seq.sv - directed self-checking bench for bg_tile_fetch_seq
module tb_bg_tile_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] nt_start_addr;
    logic [5:0]  tile_count;
    logic        pt_sel;
    logic [2:0]  fine_y;
    logic        vram_req;
    logic [15:0] vram_addr;
    logic        vram_gnt;
    logic        vram_rvalid;
    logic [7:0]  vram_rdata;
    logic        tile_valid;
    logic [7:0]  tile_pt_lo;
    logic [7:0]  tile_pt_hi;
    logic [1:0]  tile_pal;
    logic        busy;
    logic        done;
`ifdef BG_FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    bg_tile_fetch_seq #(.CNT_W(6), .AT_BASE(16'h03C0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .nt_start_addr (nt_start_addr),
        .tile_count    (tile_count),
        .pt_sel        (pt_sel),
        .fine_y        (fine_y),
        .vram_req      (vram_req),
        .vram_addr     (vram_addr),
        .vram_gnt      (vram_gnt),
        .vram_rvalid   (vram_rvalid),
        .vram_rdata    (vram_rdata),
        .tile_valid    (tile_valid),
        .tile_pt_lo    (tile_pt_lo),
        .tile_pt_hi    (tile_pt_hi),
        .tile_pal      (tile_pal),
`ifdef BG_FETCH_STALL_CNT_EN
        .stall_cnt     (stall_cnt),
`endif
        .busy          (busy),
        .done          (done)
    );

    int pass_cnt;
    int total_cnt;
    int cyc;
    int start_cyc;
    int rv_cyc;
    int req_cnt;
    int at_req_cnt;
    int ab, tb, db;

    logic [15:0] addr_q[$];
    int          tv_cyc[$];
    logic [17:0] tv_data[$];
    int          done_cyc[$];

    logic [7:0]  at_byte;
    logic [15:0] hold_addr;
    int          hold_n;
    logic [15:0] rv_addr;
    int          rv_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_data(input logic [15:0] a);
        if (a[13]) begin
            if (a[9:0] >= 10'h3C0) return at_byte;
            return 8'h24 + {3'b000, a[4:0]};
        end
        return a[7:0] + 8'h11;
    endfunction

    // Arbiter/memory model: optional gnt hold on one address, optional rvalid delay on one address.
    initial begin : responder
        logic        pending;
        logic [15:0] paddr;
        int          rv_cnt;
        int          held_cnt;
        pending = 1'b0; paddr = 16'h0; rv_cnt = 0; held_cnt = 0; rv_cyc = 0;
        vram_gnt = 1'b0; vram_rvalid = 1'b0; vram_rdata = 8'h00;
        forever begin
            @(negedge clk);
            vram_gnt    = 1'b0;
            vram_rvalid = 1'b0;
            if (!rst_n) begin
                pending  = 1'b0;
                held_cnt = 0;
            end else begin
                if (!busy) held_cnt = 0;
                if (pending) begin
                    if (rv_cnt == 0) begin
                        vram_rvalid = 1'b1;
                        vram_rdata  = mem_data(paddr);
                        pending     = 1'b0;
                        rv_cyc      = cyc;
                    end else begin
                        rv_cnt--;
                    end
                end else if (vram_req) begin
                    if (vram_addr == hold_addr && held_cnt < hold_n) begin
                        held_cnt++;
                    end else begin
                        vram_gnt = 1'b1;
                        pending  = 1'b1;
                        paddr    = vram_addr;
                        rv_cnt   = (vram_addr == rv_addr) ? rv_n : 0;
                        addr_q.push_back(vram_addr);
                    end
                end
            end
        end
    end

    initial begin : monitor
        req_cnt = 0; at_req_cnt = 0;
        forever begin
            @(negedge clk);
            if (tile_valid) begin
                tv_cyc.push_back(cyc);
                tv_data.push_back({tile_pal, tile_pt_hi, tile_pt_lo});
            end
            if (done) done_cyc.push_back(cyc);
            if (vram_req) req_cnt++;
            if (vram_req && vram_addr == 16'h23C0) at_req_cnt++;
        end
    end

    task automatic mark();
        ab = addr_q.size();
        tb = tv_cyc.size();
        db = done_cyc.size();
    endtask

    task automatic start_run(input logic [15:0] a, input logic [5:0] n,
                             input logic ps, input logic [2:0] fy);
        @(negedge clk);
        mark();
        nt_start_addr = a; tile_count = n; pt_sel = ps; fine_y = fy;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        #1;
        while (done_cyc.size() <= db && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cyc.size() <= db) begin
            total_cnt++;
            $display("FAIL %s timeout waiting for done after %0d cycles", name, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({vram_req, vram_addr, tile_valid, tile_pt_lo, tile_pt_hi, tile_pal, busy, done} !== 38'd0)
            $display("FAIL reset_outputs got %h required 0",
                     {vram_req, vram_addr, tile_valid, tile_pt_lo, tile_pt_hi, tile_pal, busy, done});
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({vram_req, busy, done} !== 3'b000)
            $display("FAIL idle_after_release got %b required 000", {vram_req, busy, done});
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [15:0] exp_a[8];
        exp_a = '{16'h2000, 16'h23C0, 16'h1243, 16'h124B, 16'h2001, 16'h23C0, 16'h1253, 16'h125B};
        start_run(16'h2000, 6'd2, 1'b1, 3'd3);
        wait_done("basic");
        total_cnt++;
        if (addr_q.size() - ab != 8) $display("FAIL basic_nreads got %0d required 8", addr_q.size() - ab);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (addr_q.size() > ab + i && addr_q[ab + i] === exp_a[i]) pass_cnt++;
            else $display("FAIL basic_addr%0d got %h required %h", i,
                          (addr_q.size() > ab + i) ? addr_q[ab + i] : 16'hxxxx, exp_a[i]);
        end
        total_cnt++;
        if (tv_cyc.size() - tb != 2) $display("FAIL basic_ntiles got %0d required 2", tv_cyc.size() - tb);
        else begin
            pass_cnt++;
            total_cnt++;
            if (tv_cyc[tb] - start_cyc != 9) $display("FAIL basic_latency got %0d required 9", tv_cyc[tb] - start_cyc);
            else pass_cnt++;
            total_cnt++;
            if (tv_cyc[tb + 1] - tv_cyc[tb] != 9) $display("FAIL basic_period got %0d required 9", tv_cyc[tb + 1] - tv_cyc[tb]);
            else pass_cnt++;
            total_cnt++;
            if (tv_data[tb] !== {2'b00, 8'h5C, 8'h54}) $display("FAIL basic_tile0 got %h required %h", tv_data[tb], {2'b00, 8'h5C, 8'h54});
            else pass_cnt++;
            total_cnt++;
            if (tv_data[tb + 1] !== {2'b00, 8'h6C, 8'h64}) $display("FAIL basic_tile1 got %h required %h", tv_data[tb + 1], {2'b00, 8'h6C, 8'h64});
            else pass_cnt++;
            total_cnt++;
            if (done_cyc.size() > db && done_cyc[db] == tv_cyc[tb + 1] + 1) pass_cnt++;
            else $display("FAIL basic_done_cycle got %0d required %0d",
                          (done_cyc.size() > db) ? done_cyc[db] : -1, tv_cyc[tb + 1] + 1);
        end
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({busy, tile_pt_hi, tile_pt_lo} !== {1'b0, 8'h6C, 8'h64})
            $display("FAIL basic_hold got %h required %h", {busy, tile_pt_hi, tile_pt_lo}, {1'b0, 8'h6C, 8'h64});
        else pass_cnt++;
    endtask

    task automatic test_quadrant();
        logic [15:0] qa[3];
        logic [1:0]  qp[3];
        qa = '{16'h2042, 16'h2002, 16'h2040};
        qp = '{2'd3, 2'd1, 2'd2};
        for (int i = 0; i < 3; i++) begin
            start_run(qa[i], 6'd1, 1'b0, 3'd0);
            wait_done("quadrant");
            total_cnt++;
            if (addr_q.size() > ab + 1 && addr_q[ab + 1] === 16'h23C0) pass_cnt++;
            else $display("FAIL quad_at_addr%0d got %h required 23c0", i,
                          (addr_q.size() > ab + 1) ? addr_q[ab + 1] : 16'hxxxx);
            total_cnt++;
            if (tv_data.size() > tb && tv_data[tb][17:16] === qp[i]) pass_cnt++;
            else $display("FAIL quad_pal%0d got %0d required %0d", i,
                          (tv_data.size() > tb) ? tv_data[tb][17:16] : 2'bxx, qp[i]);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] wa[4];
        int          wi[4];
        wa = '{16'h201F, 16'h23C7, 16'h2400, 16'h27C0};
        wi = '{0, 1, 4, 5};
        start_run(16'h201F, 6'd2, 1'b0, 3'd0);
        wait_done("wrap");
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (addr_q.size() > ab + wi[i] && addr_q[ab + wi[i]] === wa[i]) pass_cnt++;
            else $display("FAIL wrap_addr%0d got %h required %h", wi[i],
                          (addr_q.size() > ab + wi[i]) ? addr_q[ab + wi[i]] : 16'hxxxx, wa[i]);
        end
    endtask

    task automatic test_stall();
        int at0;
        at0 = at_req_cnt;
        hold_addr = 16'h23C0;
        hold_n    = 5;
        start_run(16'h2000, 6'd1, 1'b1, 3'd3);
        wait_done("stall");
        total_cnt++;
        if (tv_cyc.size() > tb && tv_cyc[tb] - start_cyc == 14) pass_cnt++;
        else $display("FAIL stall_period got %0d required 14",
                      (tv_cyc.size() > tb) ? tv_cyc[tb] - start_cyc : -1);
        total_cnt++;
        if (at_req_cnt - at0 != 6) $display("FAIL stall_addr_stable got %0d required 6", at_req_cnt - at0);
        else pass_cnt++;
`ifdef BG_FETCH_STALL_CNT_EN
        total_cnt++;
        if (stall_cnt !== 16'd5) $display("FAIL stall_cnt got %0d required 5", stall_cnt);
        else pass_cnt++;
`endif
        hold_n = 0;
    endtask

    task automatic test_abort();
        int n;
        int r0;
        rv_addr = 16'h0240;
        rv_n    = 3;
        start_run(16'h2000, 6'd2, 1'b0, 3'd0);
        n = 0;
        #1;
        while (addr_q.size() < ab + 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("abort");
        r0 = req_cnt;
        total_cnt++;
        if (done_cyc.size() > db && done_cyc[db] == rv_cyc + 1) pass_cnt++;
        else $display("FAIL abort_done_cycle got %0d required %0d",
                      (done_cyc.size() > db) ? done_cyc[db] : -1, rv_cyc + 1);
        repeat (20) @(negedge clk);
        total_cnt++;
        if (tv_cyc.size() != tb) $display("FAIL abort_no_tile got %0d required 0", tv_cyc.size() - tb);
        else pass_cnt++;
        total_cnt++;
        if (addr_q.size() - ab != 3 || req_cnt != r0)
            $display("FAIL abort_no_req got %0d reads %0d late reqs required 3 reads 0 late reqs",
                     addr_q.size() - ab, req_cnt - r0);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL abort_busy got %b required 0", busy);
        else pass_cnt++;
        rv_addr = 16'hFFFF;
        rv_n    = 0;

        r0 = req_cnt;
        start_run(16'h2000, 6'd0, 1'b0, 3'd0);
        wait_done("count0");
        total_cnt++;
        if (done_cyc.size() > db && done_cyc[db] == start_cyc + 1) pass_cnt++;
        else $display("FAIL count0_done got %0d required %0d",
                      (done_cyc.size() > db) ? done_cyc[db] : -1, start_cyc + 1);
        repeat (5) @(negedge clk);
        total_cnt++;
        if (req_cnt != r0 || busy !== 1'b0)
            $display("FAIL count0_no_req got reqs=%0d busy=%b required reqs=0 busy=0", req_cnt - r0, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n;
        hold_addr = 16'h0248;
        hold_n    = 100;
        start_run(16'h2000, 6'd1, 1'b0, 3'd0);
        n = 0;
        #1;
        while (!(vram_req && vram_addr == 16'h0248) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        total_cnt++;
        if (!(vram_req && vram_addr == 16'h0248)) $display("FAIL rstmid_reach_ph got %h required 0248", vram_addr);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({vram_req, vram_addr, tile_valid, tile_pt_lo, tile_pt_hi, tile_pal, busy, done} !== 38'd0)
            $display("FAIL rstmid_outputs got %h required 0",
                     {vram_req, vram_addr, tile_valid, tile_pt_lo, tile_pt_hi, tile_pal, busy, done});
        else pass_cnt++;
        @(negedge clk);
        rst_n  = 1'b1;
        hold_n = 0;
        start_run(16'h2000, 6'd1, 1'b1, 3'd3);
        wait_done("rstmid_rerun");
        total_cnt++;
        if (addr_q.size() > ab && addr_q[ab] === 16'h2000) pass_cnt++;
        else $display("FAIL rstmid_first_addr got %h required 2000",
                      (addr_q.size() > ab) ? addr_q[ab] : 16'hxxxx);
        total_cnt++;
        if (tv_data.size() == tb + 1 && tv_data[tb] === {2'b00, 8'h5C, 8'h54}) pass_cnt++;
        else $display("FAIL rstmid_tile got %h required %h",
                      (tv_data.size() > tb) ? tv_data[tb] : 18'hx, {2'b00, 8'h5C, 8'h54});
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0; cyc = 0; start_cyc = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        nt_start_addr = 16'h0000; tile_count = 6'd0; pt_sel = 1'b0; fine_y = 3'd0;
        at_byte = 8'hE4;
        hold_addr = 16'hFFFF; hold_n = 0;
        rv_addr = 16'hFFFF; rv_n = 0;
        ab = 0; tb = 0; db = 0;
        test_reset();
        test_basic();
        test_quadrant();
        test_wrap();
        test_stall();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
